// File: rtl/adder_accumulator.sv
// adder_accumulator: sums a run of 5-bit adder results and counts their carry-outs.
// A run starts from IDLE on start and takes count samples, where a count of 0
// means 16. The total and carry count are then held in DONE until the consumer
// takes them with out_ready.
module adder_accumulator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] count,
    input  logic       in_valid,
    input  logic [4:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] sum,
    output logic [4:0] carry_count,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0] state;
    // Samples still owed in the current run. Five bits are needed so it can hold 16.
    logic [4:0] remaining;

    // Handshakes decode the registered state only, so in_valid has no path to in_ready.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACCUM) || (state == DONE);

    // FSM, sample counter and result registers. sum and carry_count are not
    // touched in IDLE, so the last result stays readable until the next start.
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= 5'd0;
            sum         <= 9'd0;
            carry_count <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ACCUM;
                        remaining   <= (count == 4'd0) ? 5'd16 : {1'b0, count};
                        sum         <= 9'd0;
                        carry_count <= 5'd0;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        // 16 x 31 = 496 fits in 9 bits, so neither sum nor carry_count wraps.
                        sum         <= sum + {4'd0, in_data};
                        carry_count <= carry_count + {4'd0, in_data[4]};
                        remaining   <= remaining - 5'd1;
                        if (remaining == 5'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
